// File: rtl/pixel_fetch_if.sv
// Bundle between pixel_fetch, the framebuffer ROM, the pixel FIFO and the timing generator.
// master = pixel_fetch side; slave = environment side.
interface pixel_fetch_if #(
    parameter int ADDR_W = 19
) ();
    logic              frame_start;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [23:0]       fifo_wdata;
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic              busy;
    logic              frame_done;

    modport master (
        input  frame_start, fifo_full, rom_data,
        output fifo_wr_en, fifo_wdata, rom_rd_en, rom_addr, busy, frame_done
    );

    modport slave (
        output frame_start, fifo_full, rom_data,
        input  fifo_wr_en, fifo_wdata, rom_rd_en, rom_addr, busy, frame_done
    );
endinterface

// File: rtl/pixel_fetch.sv
// Linear framebuffer ROM walker feeding the DVI pixel FIFO through a one-entry skid register.
// Optional: define PIXEL_FETCH_RESYNC_EN to let frame_start abort and restart a frame in flight.
module pixel_fetch #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    pixel_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic              rd_pending_r;
    logic              skid_valid_r;
    logic [23:0]       skid_data_r;
    logic [23:0]       wdata_hold_r;
    logic              rd_en_s;
    logic              wr_en_s;
    logic [23:0]       wdata_s;
    logic              done_s;
    logic              restart_s;

    // Next-state, read issue and FIFO write selection
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        rd_en_s   = 1'b0;
        wr_en_s   = 1'b0;
        wdata_s   = wdata_hold_r;
        done_s    = 1'b0;
        restart_s = 1'b0;

        // A skid word and a ROM return never coexist: no read is issued while the skid is full.
        if (skid_valid_r && !bus.fifo_full) begin
            wr_en_s = 1'b1;
            wdata_s = skid_data_r;
        end else if (rd_pending_r && !skid_valid_r && !bus.fifo_full) begin
            wr_en_s = 1'b1;
            wdata_s = bus.rom_data;
        end else begin
            wr_en_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    state_s   = ST_FETCH;
                    addr_s    = FIRST_ADDR;
                    restart_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                rd_en_s = !bus.fifo_full && !skid_valid_r;
                if (rd_en_s) begin
                    addr_s  = addr_r + ADDR_W'(1);
                    state_s = (addr_r == LAST_ADDR) ? ST_DRAIN : ST_FETCH;
                end else begin
                    state_s = ST_FETCH;
                end
`ifdef PIXEL_FETCH_RESYNC_EN
                if (bus.frame_start) begin
                    state_s   = ST_FETCH;
                    addr_s    = FIRST_ADDR;
                    restart_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
`endif
            end
            ST_DRAIN: begin
                if (wr_en_s) begin
                    done_s = 1'b1;
                    if (bus.frame_start) begin
                        state_s   = ST_FETCH;
                        addr_s    = FIRST_ADDR;
                        restart_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
`ifdef PIXEL_FETCH_RESYNC_EN
                    if (bus.frame_start) begin
                        state_s   = ST_FETCH;
                        addr_s    = FIRST_ADDR;
                        restart_s = 1'b1;
                    end else begin
                        state_s = ST_DRAIN;
                    end
`else
                    state_s = ST_DRAIN;
`endif
                end
            end
            default: begin
                state_s = ST_IDLE;
                addr_s  = FIRST_ADDR;
            end
        endcase
    end

    // State, address, in-flight tracking, skid and write-data hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= FIRST_ADDR;
            rd_pending_r <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 24'd0;
            wdata_hold_r <= 24'd0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            // A read issued in the restart cycle belongs to the abandoned frame.
            rd_pending_r <= rd_en_s && !restart_s;
            if (restart_s) begin
                skid_valid_r <= 1'b0;
            end else if (rd_pending_r && bus.fifo_full) begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= bus.rom_data;
            end else if (skid_valid_r && !bus.fifo_full) begin
                skid_valid_r <= 1'b0;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
            if (wr_en_s) begin
                wdata_hold_r <= wdata_s;
            end else begin
                wdata_hold_r <= wdata_hold_r;
            end
        end
    end

    assign bus.rom_rd_en  = rd_en_s;
    assign bus.rom_addr   = addr_r;
    assign bus.fifo_wr_en = wr_en_s;
    assign bus.fifo_wdata = wdata_s;
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.frame_done = done_s;

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch on a 4x2 frame; ROM word = addr * 0x010101.
module tb_pixel_fetch;
    localparam int AW   = 19;
    localparam int NPIX = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pixel_fetch_if #(.ADDR_W(AW)) bus ();

    pixel_fetch #(
        .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    function automatic logic [23:0] rom_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b, b, b};
    endfunction

    // ROM model: data valid one cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        if (bus.rom_rd_en) bus.rom_data <= rom_word(int'(bus.rom_addr));
        else bus.rom_data <= 24'hA5A5A5;
    end

    logic [23:0] wlog[$];
    int          wr_full_cnt = 0;
    int          done_cnt = 0;

    // Write log and protocol counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.fifo_wr_en) begin
            wlog.push_back(bus.fifo_wdata);
            if (bus.fifo_full) wr_full_cnt <= wr_full_cnt + 1;
        end
        if (bus.frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.frame_start = 1'b0; bus.fifo_full = 1'b0;
        repeat (3) tick();
        sample();
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.fifo_wdata !== 24'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 000000", bus.fifo_wdata); end
        n_cmp++; if (bus.rom_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", bus.rom_rd_en); end
        n_cmp++; if (bus.rom_addr !== 19'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
        tick(); rst = 1'b0;
    endtask

    // Per-cycle check of a frame with fifo_full high in cycles [fs, fe]; frame_start at cycle 0
    task automatic test_frame(input string nm, input int fs, input int fe,
                              input int rd_lo, input int rd_hi, input int rd_lo2, input int rd_hi2,
                              input int skid_k, input int done_k, input int last_k);
        int nexp;
        logic exp_rd, exp_wr, exp_busy;
        logic [23:0] exp_data;
        nexp = 0;
        exp_data = bus.fifo_wdata;
        for (int k = 0; k <= last_k; k++) begin
            tick();
            bus.frame_start = (k == 0);
            bus.fifo_full = (k >= fs && k <= fe);
            sample();
            exp_rd = (k >= rd_lo && k <= rd_hi) || (k >= rd_lo2 && k <= rd_hi2);
            exp_wr = (k == skid_k) || (k >= 2 && k <= done_k && !(k >= fs && k <= fe) && k != skid_k + 1);
            exp_busy = (k >= 1 && k <= done_k);
            if (exp_wr) begin exp_data = rom_word(nexp); nexp++; end
            n_cmp++; if (bus.rom_rd_en !== exp_rd) begin n_bad++; $display("FAIL %s_rd_en k=%0d: got %b want %b", nm, k, bus.rom_rd_en, exp_rd); end
            if (exp_rd) begin
                n_cmp++; if (bus.rom_addr !== AW'(k - rd_lo - ((k >= rd_lo2) ? (rd_lo2 - rd_hi - 1) : 0))) begin n_bad++; $display("FAIL %s_addr k=%0d: got %0d", nm, k, bus.rom_addr); end
            end
            n_cmp++; if (bus.fifo_wr_en !== exp_wr) begin n_bad++; $display("FAIL %s_wr_en k=%0d: got %b want %b", nm, k, bus.fifo_wr_en, exp_wr); end
            n_cmp++; if (bus.fifo_wdata !== exp_data) begin n_bad++; $display("FAIL %s_wdata k=%0d: got %h want %h", nm, k, bus.fifo_wdata, exp_data); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_bad++; $display("FAIL %s_busy k=%0d: got %b want %b", nm, k, bus.busy, exp_busy); end
            n_cmp++; if (bus.frame_done !== (k == done_k)) begin n_bad++; $display("FAIL %s_done k=%0d: got %b want %b", nm, k, bus.frame_done, (k == done_k)); end
        end
        bus.fifo_full = 1'b0;
        n_cmp++; if (nexp !== NPIX) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", nm, nexp, NPIX); end
    endtask

    task automatic test_random();
        int wb, db, wf, k;
        bit seen;
        for (int f = 0; f < 3; f++) begin
            wb = wlog.size(); db = done_cnt; wf = wr_full_cnt;
            seen = 1'b0; k = 0;
            while (!seen && k < 200) begin
                tick();
                bus.frame_start = (k == 0);
                bus.fifo_full = 1'($urandom_range(0, 1));
                sample();
                seen = bus.frame_done;
                k++;
            end
            tick(); bus.fifo_full = 1'b0;
            n_cmp++; if (!seen) begin n_bad++; $display("FAIL random_timeout f=%0d: no frame_done in 200 cycles", f); end
            n_cmp++; if (wlog.size() - wb !== NPIX) begin n_bad++; $display("FAIL random_count f=%0d: got %0d want %0d", f, wlog.size() - wb, NPIX); end
            n_cmp++; if (wr_full_cnt !== wf) begin n_bad++; $display("FAIL random_wr_while_full f=%0d: got %0d want 0", f, wr_full_cnt - wf); end
            n_cmp++; if (done_cnt - db !== 1) begin n_bad++; $display("FAIL random_done f=%0d: got %0d want 1", f, done_cnt - db); end
            for (int i = 0; i < NPIX; i++) begin
                n_cmp++;
                if (((wb + i < wlog.size()) ? wlog[wb + i] : 24'hFFFFFF) !== rom_word(i)) begin
                    n_bad++; $display("FAIL random_order f=%0d i=%0d: want %h", f, i, rom_word(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int wb, k;
        bit seen;
        for (int c = 0; c <= 6; c++) begin
            tick();
            bus.frame_start = (c == 0);
            bus.fifo_full = (c >= 4);
            rst = (c == 5);
            sample();
            if (c == 5) begin
                n_cmp++; if (bus.rom_addr !== 19'd3) begin n_bad++; $display("FAIL rstmid_pre_addr: got %0d want 3", bus.rom_addr); end
            end
        end
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr_en: got %b want 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.fifo_wdata !== 24'd0) begin n_bad++; $display("FAIL rstmid_wdata: got %h want 000000", bus.fifo_wdata); end
        n_cmp++; if (bus.rom_rd_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd_en: got %b want 0", bus.rom_rd_en); end
        n_cmp++; if (bus.rom_addr !== 19'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", bus.rom_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", bus.frame_done); end
        tick(); bus.fifo_full = 1'b0;
        wb = wlog.size(); seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            tick();
            bus.frame_start = (k == 0);
            sample();
            seen = bus.frame_done;
            k++;
        end
        tick();
        n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL rstmid_restart_done_cycle: got %0d want 10", k); end
        n_cmp++; if (wlog.size() - wb !== NPIX) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", wlog.size() - wb, NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            n_cmp++;
            if (((wb + i < wlog.size()) ? wlog[wb + i] : 24'hFFFFFF) !== rom_word(i)) begin
                n_bad++; $display("FAIL rstmid_order i=%0d: want %h", i, rom_word(i));
            end
        end
    endtask

    task automatic test_restart();
        int wb, ndone, done_k, nexp;
        logic [23:0] exp_q[$];
        logic exp_wr7;
        wb = wlog.size(); ndone = 0; done_k = -1;
`ifdef PIXEL_FETCH_RESYNC_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(rom_word(i));
        exp_wr7 = 1'b0;
`else
        exp_wr7 = 1'b1;
`endif
        for (int i = 0; i < NPIX; i++) exp_q.push_back(rom_word(i));
        for (int k = 0; k <= 20; k++) begin
            tick();
            bus.frame_start = (k == 0 || k == 6);
            sample();
            if (k == 6) begin
                n_cmp++; if (bus.rom_addr !== 19'd5) begin n_bad++; $display("FAIL restart_addr5: got %0d want 5", bus.rom_addr); end
            end
            if (k == 7) begin
                n_cmp++; if (bus.fifo_wr_en !== exp_wr7) begin n_bad++; $display("FAIL restart_wr7: got %b want %b", bus.fifo_wr_en, exp_wr7); end
            end
            if (bus.frame_done) begin ndone++; done_k = k; end
        end
        tick();
        nexp = exp_q.size();
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL restart_ndone: got %0d want 1", ndone); end
`ifdef PIXEL_FETCH_RESYNC_EN
        n_cmp++; if (done_k !== 15) begin n_bad++; $display("FAIL restart_done_k: got %0d want 15", done_k); end
`else
        n_cmp++; if (done_k !== 9) begin n_bad++; $display("FAIL restart_done_k: got %0d want 9", done_k); end
`endif
        n_cmp++; if (wlog.size() - wb !== nexp) begin n_bad++; $display("FAIL restart_count: got %0d want %0d", wlog.size() - wb, nexp); end
        for (int i = 0; i < nexp; i++) begin
            n_cmp++;
            if (((wb + i < wlog.size()) ? wlog[wb + i] : 24'hFFFFFF) !== exp_q[i]) begin
                n_bad++; $display("FAIL restart_order i=%0d: want %h", i, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wb, ndone;
        wb = wlog.size(); ndone = 0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            bus.frame_start = (k == 0 || k == 9);
            sample();
            if (k == 9) begin
                n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done9: got %b want 1", bus.frame_done); end
            end
            if (k == 10) begin
                n_cmp++; if (bus.rom_rd_en !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_en10: got %b want 1", bus.rom_rd_en); end
                n_cmp++; if (bus.rom_addr !== 19'd0) begin n_bad++; $display("FAIL b2b_addr10: got %0d want 0", bus.rom_addr); end
                n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy10: got %b want 1", bus.busy); end
            end
            if (k == 18) begin
                n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done18: got %b want 1", bus.frame_done); end
            end
            if (bus.frame_done) ndone++;
        end
        tick();
        n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_ndone: got %0d want 2", ndone); end
        n_cmp++; if (wlog.size() - wb !== 2 * NPIX) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", wlog.size() - wb, 2 * NPIX); end
        for (int i = 0; i < 2 * NPIX; i++) begin
            n_cmp++;
            if (((wb + i < wlog.size()) ? wlog[wb + i] : 24'hFFFFFF) !== rom_word(i % NPIX)) begin
                n_bad++; $display("FAIL b2b_order i=%0d: want %h", i, rom_word(i % NPIX));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.fifo_full = 1'b0;
        test_reset();
        // Unstalled: reads k=1..8, writes k=2..9, done k=9
        test_frame("basic", 99, 98, 1, 8, 99, 98, -5, 9, 11);
        // fifo_full k=4..6: reads k=1..3 and 8..12, skid written k=7, done k=13
        test_frame("stall", 4, 6, 1, 3, 8, 12, 7, 13, 15);
        test_random();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
